// File: rtl/bus_sync_pkg.sv
// Shared constants and parameter checks for the bus_sync_pulse CDC receiver.
package bus_sync_pkg;

    localparam int ENABLE_MODE_LEVEL  = 0;
    localparam int ENABLE_MODE_TOGGLE = 1;

    function automatic bit params_ok(input int num_stages,
                                     input int bus_width,
                                     input int cnt_width);
        return (num_stages >= 2) && (bus_width >= 1) && (cnt_width >= 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop synchroniser with asynchronous active-high reset.
module sync_chain #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/bus_sync_pulse.sv
// Multi-bit CDC receiver: synchronised qualifier, bus capture, pulse, counter.
module bus_sync_pulse
    import bus_sync_pkg::*;
#(
    parameter int NUM_STAGES  = 2,
    parameter int BUS_WIDTH   = 8,
    parameter int ENABLE_MODE = 0,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_ENABLE,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE,
    output logic [CNT_WIDTH-1:0] XFER_CNT
);

    generate
        if (!params_ok(NUM_STAGES, BUS_WIDTH, CNT_WIDTH)) begin : g_bad_params
            $error("bus_sync_pulse: illegal parameter combination");
        end
    endgenerate

    logic en_sync;
    logic en_prev;
    logic xfer_event;

    sync_chain #(
        .STAGES (NUM_STAGES),
        .WIDTH  (1)
    ) u_en_sync (
        .clk (CLK),
        .rst (RST),
        .d   (BUS_ENABLE),
        .q   (en_sync)
    );

    always_comb begin
        xfer_event = 1'b0;
        if (ENABLE_MODE == ENABLE_MODE_TOGGLE) begin
            xfer_event = en_sync ^ en_prev;
        end else begin
            xfer_event = en_sync & ~en_prev;
        end
    end

    // The bus is only ever sampled here, once the qualifier has settled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            en_prev      <= 1'b0;
            SYNC_BUS     <= '0;
            ENABLE_PULSE <= 1'b0;
            XFER_CNT     <= '0;
        end else begin
            en_prev      <= en_sync;
            ENABLE_PULSE <= xfer_event;
            if (xfer_event) begin
                SYNC_BUS <= UNSYNC_BUS;
                if (XFER_CNT != '1) begin
                    XFER_CNT <= XFER_CNT + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_sync_pulse.sv
// Directed bench: LEVEL, TOGGLE and 4-stage LEVEL instances on one clock.
module tb_bus_sync_pulse;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus;
    logic       en_l;
    logic       en_t;
    logic       en_d;

    logic [7:0] sb_l, sb_t, sb_d;
    logic       p_l, p_t, p_d;
    logic [1:0] c_l, c_t;
    logic [7:0] c_d;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    bus_sync_pulse #(.NUM_STAGES(2), .BUS_WIDTH(8), .ENABLE_MODE(0), .CNT_WIDTH(2)) u_lvl (
        .CLK(clk), .RST(rst), .UNSYNC_BUS(bus), .BUS_ENABLE(en_l),
        .SYNC_BUS(sb_l), .ENABLE_PULSE(p_l), .XFER_CNT(c_l));

    bus_sync_pulse #(.NUM_STAGES(2), .BUS_WIDTH(8), .ENABLE_MODE(1), .CNT_WIDTH(2)) u_tog (
        .CLK(clk), .RST(rst), .UNSYNC_BUS(bus), .BUS_ENABLE(en_t),
        .SYNC_BUS(sb_t), .ENABLE_PULSE(p_t), .XFER_CNT(c_t));

    bus_sync_pulse #(.NUM_STAGES(4), .BUS_WIDTH(8), .ENABLE_MODE(0), .CNT_WIDTH(8)) u_deep (
        .CLK(clk), .RST(rst), .UNSYNC_BUS(bus), .BUS_ENABLE(en_d),
        .SYNC_BUS(sb_d), .ENABLE_PULSE(p_d), .XFER_CNT(c_d));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        bus  = 8'h00;
        en_l = 1'b0;
        en_t = 1'b0;
        en_d = 1'b0;

        cyc(3);
        chk("reset_lvl_pulse", 32'(p_l), 32'd0);
        chk("reset_lvl_bus", 32'(sb_l), 32'd0);
        chk("reset_lvl_cnt", 32'(c_l), 32'd0);
        chk("reset_tog_bus", 32'(sb_t), 32'd0);
        chk("reset_deep_cnt", 32'(c_d), 32'd0);
        rst = 1'b0;

        // Level basic + 4-stage depth: enable rises between edge 0 and 1
        bus  = 8'hA5;
        en_l = 1'b1;
        en_d = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cyc(1);
            chk($sformatf("lvl_pulse_e%0d", k), 32'(p_l), 32'(k == 3));
            chk($sformatf("deep_pulse_e%0d", k), 32'(p_d), 32'(k == 5));
            if (k == 3) begin
                chk("lvl_bus_e3", 32'(sb_l), 32'hA5);
                chk("lvl_cnt_e3", 32'(c_l), 32'd1);
            end
            if (k == 5) begin
                chk("deep_bus_e5", 32'(sb_d), 32'hA5);
                chk("deep_cnt_e5", 32'(c_d), 32'd1);
            end
        end
        cyc(3);
        en_l = 1'b0;
        en_d = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk($sformatf("lvl_fall_nopulse_%0d", k), 32'(p_l), 32'd0);
            chk($sformatf("deep_fall_nopulse_%0d", k), 32'(p_d), 32'd0);
        end
        chk("lvl_bus_held", 32'(sb_l), 32'hA5);
        chk("lvl_cnt_held", 32'(c_l), 32'd1);

        // Toggle mode: rise then fall six cycles later
        bus  = 8'h11;
        en_t = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            chk($sformatf("tog1_pulse_e%0d", k), 32'(p_t), 32'(k == 3));
            if (k == 3) begin
                chk("tog1_bus", 32'(sb_t), 32'h11);
                chk("tog1_cnt", 32'(c_t), 32'd1);
            end
        end
        bus  = 8'h22;
        en_t = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            chk($sformatf("tog2_pulse_e%0d", k), 32'(p_t), 32'(k == 3));
            if (k == 3) begin
                chk("tog2_bus", 32'(sb_t), 32'h22);
                chk("tog2_cnt", 32'(c_t), 32'd2);
            end
        end

        // Saturation of the 2-bit counter after a fresh reset
        rst = 1'b1;
        #2;
        chk("sat_reset_cnt", 32'(c_l), 32'd0);
        cyc(1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus  = 8'(i);
            en_l = 1'b1;
            cyc(2);
            chk($sformatf("sat_prepulse_%0d", i), 32'(p_l), 32'd0);
            cyc(1);
            chk($sformatf("sat_pulse_%0d", i), 32'(p_l), 32'd1);
            chk($sformatf("sat_bus_%0d", i), 32'(sb_l), 32'(i));
            chk($sformatf("sat_cnt_%0d", i), 32'(c_l), 32'((i < 2) ? i + 1 : 3));
            cyc(1);
            chk($sformatf("sat_postpulse_%0d", i), 32'(p_l), 32'd0);
            en_l = 1'b0;
            cyc(4);
        end
        chk("sat_final_bus", 32'(sb_l), 32'd4);
        chk("sat_final_cnt", 32'(c_l), 32'd3);

        // Reset while an event is still in the chain
        bus  = 8'h5A;
        en_l = 1'b1;
        cyc(1);
        rst = 1'b1;
        #1;
        chk("mid_rst_pulse", 32'(p_l), 32'd0);
        chk("mid_rst_bus", 32'(sb_l), 32'd0);
        chk("mid_rst_cnt", 32'(c_l), 32'd0);
        cyc(1);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            chk($sformatf("post_rst_pulse_e%0d", k), 32'(p_l), 32'(k == 3));
            if (k == 3) begin
                chk("post_rst_bus", 32'(sb_l), 32'h5A);
                chk("post_rst_cnt", 32'(c_l), 32'd1);
            end
        end

        // Bus isolation: bus churns, qualifiers static
        for (int k = 0; k < 50; k++) begin
            bus = 8'($urandom);
            cyc(1);
            chk($sformatf("iso_lvl_pulse_%0d", k), 32'(p_l), 32'd0);
            chk($sformatf("iso_lvl_bus_%0d", k), 32'(sb_l), 32'h5A);
            chk($sformatf("iso_tog_pulse_%0d", k), 32'(p_t), 32'd0);
            chk($sformatf("iso_tog_bus_%0d", k), 32'(sb_t), 32'd0);
        end
        chk("iso_lvl_cnt", 32'(c_l), 32'd1);
        chk("iso_tog_cnt", 32'(c_t), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
